// File: rtl/alu_sequencer_pkg.sv
// Shared state encoding and default constants for the ALU sequencer.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package def_pack;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_ERROR  = 3'd7
  } seq_state_e;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/alu_sequencer_timeout.sv
// Memory-wait watchdog: counts wait cycles, flags expiry on the LIMIT-th one.
// Latency: expired is combinational from the current count and count_en.
// Backpressure: none; LIMIT=0 never expires.
module seq_timeout_counter #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  logic [31:0] cnt;

  // Count consecutive wait cycles; clear takes priority over counting.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= 32'd0;
    end else if (count_en) begin
      cnt <= cnt + 32'd1;
    end
  end

  // Expiry fires in the cycle whose increment would make the count reach LIMIT.
  assign expired = (LIMIT != 0) && count_en && (cnt == (LIMIT - 32'd1));

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle core control FSM: fetch, decode, execute, optional memory access, writeback.
// Latency: 4 cycles per non-memory instruction, 5 plus waits for load/store.
// Backpressure: memory requests are held until READY; the watchdog sends a stall to ERROR.
module alu_sequencer
  import def_pack::*;
#(
  parameter logic [31:0] RESET_PC    = DEF_RESET_PC,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  output logic        IMEM_REQ,
  input  logic        IMEM_READY,
  output logic        DECODE_EN,
  input  logic        IS_LOAD,
  input  logic        IS_STORE,
  input  logic        IS_BRANCH,
  input  logic        IS_JUMP,
  input  logic        IS_HALT,
  input  logic        BRANCH_TAKEN,
  input  logic [31:0] NEXT_PC,
  output logic        ALU_ENABLED,
  output logic        DMEM_REQ,
  output logic        DMEM_WE,
  input  logic        DMEM_READY,
  output logic        REG_WE,
  output logic [31:0] PC,
  output logic [2:0]  STATE,
  output logic [31:0] RETIRED,
  output logic        HALTED,
  output logic        ERR
);

  seq_state_e state;
  seq_state_e state_nxt;
  logic       wait_cycle;
  logic       to_expired;

  // A wait cycle is a FETCH or MEM cycle whose ready has not arrived.
  assign wait_cycle = ((state == S_FETCH) && !IMEM_READY) ||
                      ((state == S_MEM)   && !DMEM_READY);

  seq_timeout_counter #(
    .LIMIT (MEM_TIMEOUT)
  ) u_timeout (
    .clk      (CLK),
    .rst      (RST),
    .clear    (!wait_cycle),
    .count_en (wait_cycle),
    .expired  (to_expired)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and state-decoded strobes.
  always_comb begin
    state_nxt   = state;
    IMEM_REQ    = 1'b0;
    DECODE_EN   = 1'b0;
    ALU_ENABLED = 1'b0;
    DMEM_REQ    = 1'b0;
    DMEM_WE     = 1'b0;
    REG_WE      = 1'b0;
    HALTED      = 1'b0;
    ERR         = 1'b0;
    case (state)
      S_IDLE: begin
        if (START) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        IMEM_REQ = 1'b1;
        if (IMEM_READY)      state_nxt = S_DECODE;
        else if (to_expired) state_nxt = S_ERROR;
      end
      S_DECODE: begin
        DECODE_EN = 1'b1;
        state_nxt = S_EXEC;
      end
      S_EXEC: begin
        ALU_ENABLED = 1'b1;
        if (IS_HALT)                  state_nxt = S_HALT;
        else if (IS_LOAD || IS_STORE) state_nxt = S_MEM;
        else                          state_nxt = S_WB;
      end
      S_MEM: begin
        DMEM_REQ = 1'b1;
        // A load+store decode collision resolves as a store.
        DMEM_WE  = IS_STORE;
        if (DMEM_READY)      state_nxt = S_WB;
        else if (to_expired) state_nxt = S_ERROR;
      end
      S_WB: begin
        REG_WE    = !(IS_STORE || IS_BRANCH);
        state_nxt = S_FETCH;
      end
      S_HALT: begin
        HALTED = 1'b1;
      end
      S_ERROR: begin
        ERR = 1'b1;
      end
      default: begin
        state_nxt = S_ERROR;
      end
    endcase
  end

  // PC and retire counter advance only when an instruction completes writeback.
  always_ff @(posedge CLK) begin
    if (RST) begin
      PC      <= RESET_PC;
      RETIRED <= 32'd0;
    end else if (state == S_WB) begin
      RETIRED <= RETIRED + 32'd1;
      if (IS_JUMP || (IS_BRANCH && BRANCH_TAKEN)) PC <= NEXT_PC;
      else                                        PC <= PC + 32'd1;
    end
  end

  assign STATE = state;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed + randomized bench for alu_sequencer with a cycle-level instruction model.
module tb_alu_sequencer;

  logic        CLK = 1'b0;
  logic        RST, START, IMEM_READY, IS_LOAD, IS_STORE, IS_BRANCH, IS_JUMP, IS_HALT;
  logic        BRANCH_TAKEN, DMEM_READY;
  logic [31:0] NEXT_PC;
  logic        IMEM_REQ, DECODE_EN, ALU_ENABLED, DMEM_REQ, DMEM_WE, REG_WE, HALTED, ERR;
  logic [31:0] PC, RETIRED;
  logic [2:0]  STATE;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_pc;
  logic [31:0] m_ret;

  always #5 CLK = ~CLK;

  alu_sequencer #(
    .RESET_PC    (32'h0000_0000),
    .MEM_TIMEOUT (8)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .START        (START),
    .IMEM_REQ     (IMEM_REQ),
    .IMEM_READY   (IMEM_READY),
    .DECODE_EN    (DECODE_EN),
    .IS_LOAD      (IS_LOAD),
    .IS_STORE     (IS_STORE),
    .IS_BRANCH    (IS_BRANCH),
    .IS_JUMP      (IS_JUMP),
    .IS_HALT      (IS_HALT),
    .BRANCH_TAKEN (BRANCH_TAKEN),
    .NEXT_PC      (NEXT_PC),
    .ALU_ENABLED  (ALU_ENABLED),
    .DMEM_REQ     (DMEM_REQ),
    .DMEM_WE      (DMEM_WE),
    .DMEM_READY   (DMEM_READY),
    .REG_WE       (REG_WE),
    .PC           (PC),
    .STATE        (STATE),
    .RETIRED      (RETIRED),
    .HALTED       (HALTED),
    .ERR          (ERR)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_class();
    IS_LOAD = 0; IS_STORE = 0; IS_BRANCH = 0; IS_JUMP = 0; IS_HALT = 0;
    BRANCH_TAKEN = 0; NEXT_PC = 32'd0;
  endtask

  task automatic do_reset();
    RST = 1; START = 0; IMEM_READY = 0; DMEM_READY = 0;
    clear_class();
    @(negedge CLK);
    @(negedge CLK);
    RST = 0;
    m_pc  = 32'h0000_0000;
    m_ret = 32'd0;
  endtask

  task automatic start_run();
    START = 1;
    @(negedge CLK);
    START = 0;
  endtask

  // One full instruction, entered at a negedge with the DUT in FETCH.
  task automatic do_instr(input bit ld, input bit st, input bit br, input bit jmp,
                          input bit hlt, input bit taken, input logic [31:0] tgt,
                          input int iw, input int dw);
    for (int i = 0; i <= iw; i++) begin
      check("fetch_state", 32'(STATE), 32'd1);
      check("imem_req", 32'(IMEM_REQ), 32'd1);
      check("fetch_pc", PC, m_pc);
      check("fetch_retired", RETIRED, m_ret);
      IMEM_READY = (i == iw);
      @(negedge CLK);
    end
    IMEM_READY = 0;
    check("decode_state", 32'(STATE), 32'd2);
    check("decode_en", 32'(DECODE_EN), 32'd1);
    IS_LOAD = ld; IS_STORE = st; IS_BRANCH = br; IS_JUMP = jmp; IS_HALT = hlt;
    @(negedge CLK);
    check("exec_state", 32'(STATE), 32'd3);
    check("alu_enabled", 32'(ALU_ENABLED), 32'd1);
    BRANCH_TAKEN = taken; NEXT_PC = tgt;
    @(negedge CLK);
    if (hlt) begin
      for (int i = 0; i < 20; i++) begin
        check("halt_state", 32'(STATE), 32'd6);
        check("halted", 32'(HALTED), 32'd1);
        check("halt_imem_req", 32'(IMEM_REQ), 32'd0);
        check("halt_retired", RETIRED, m_ret);
        check("halt_pc", PC, m_pc);
        @(negedge CLK);
      end
      return;
    end
    if (ld || st) begin
      for (int i = 0; i <= dw; i++) begin
        check("mem_state", 32'(STATE), 32'd4);
        check("dmem_req", 32'(DMEM_REQ), 32'd1);
        check("dmem_we", 32'(DMEM_WE), 32'(st));
        DMEM_READY = (i == dw);
        @(negedge CLK);
      end
      DMEM_READY = 0;
    end
    check("wb_state", 32'(STATE), 32'd5);
    check("reg_we", 32'(REG_WE), 32'(!(st || br)));
    check("wb_dmem_req", 32'(DMEM_REQ), 32'd0);
    m_pc  = (jmp || (br && taken)) ? tgt : m_pc + 32'd1;
    m_ret = m_ret + 32'd1;
    @(negedge CLK);
    clear_class();
    check("next_pc", PC, m_pc);
    check("next_retired", RETIRED, m_ret);
    check("reg_we_off", 32'(REG_WE), 32'd0);
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_state", 32'(STATE), 32'd0);
    check("rst_pc", PC, 32'h0);
    check("rst_retired", RETIRED, 32'd0);
    check("rst_strobes", 32'({IMEM_REQ, DECODE_EN, ALU_ENABLED, DMEM_REQ, DMEM_WE,
                             REG_WE, HALTED, ERR}), 32'd0);
    // IDLE holds without START
    @(negedge CLK);
    check("idle_hold", 32'(STATE), 32'd0);
    start_run();

    // Directed: ALU, delayed load, taken/not-taken branch, store, load+store collision
    do_instr(0, 0, 0, 0, 0, 0, 32'h0, 0, 0);
    do_instr(1, 0, 0, 0, 0, 0, 32'h0, 0, 3);
    do_instr(0, 0, 1, 0, 0, 1, 32'h40, 1, 0);
    do_instr(0, 0, 1, 0, 0, 0, 32'h80, 0, 0);
    do_instr(0, 1, 0, 0, 0, 0, 32'h0, 2, 1);
    do_instr(1, 1, 0, 0, 0, 0, 32'h0, 0, 0);
    // PC wrap: jump to the top of the address space, then a sequential step
    do_instr(0, 0, 0, 1, 0, 0, 32'hFFFF_FFFF, 0, 0);
    do_instr(0, 0, 0, 0, 0, 0, 32'h0, 0, 0);
    check("pc_wrapped", PC, 32'h0);

    // Randomized instruction mix; waits stay below the watchdog limit
    for (int n = 0; n < 40; n++) begin
      int unsigned cls;
      bit ld, st, br, jmp;
      cls = $urandom_range(0, 5);
      ld  = (cls == 1) || (cls == 5);
      st  = (cls == 2) || (cls == 5);
      br  = (cls == 3);
      jmp = (cls == 4);
      do_instr(ld, st, br, jmp, 0, 1'($urandom_range(0, 1)), $urandom,
               int'($urandom_range(0, 6)), int'($urandom_range(0, 6)));
    end

    // Halt is terminal and does not retire
    do_instr(0, 0, 0, 0, 1, 0, 32'h0, 1, 0);
    do_reset();
    check("post_halt_state", 32'(STATE), 32'd0);
    check("post_halt_pc", PC, 32'h0);
    check("post_halt_halted", 32'(HALTED), 32'd0);

    // Fetch watchdog: eight unanswered FETCH cycles lead to ERROR
    start_run();
    for (int i = 0; i < 8; i++) begin
      check("to_fetch_state", 32'(STATE), 32'd1);
      check("to_err_low", 32'(ERR), 32'd0);
      @(negedge CLK);
    end
    check("to_err", 32'(ERR), 32'd1);
    check("to_state", 32'(STATE), 32'd7);
    IMEM_READY = 1;
    @(negedge CLK);
    IMEM_READY = 0;
    check("err_sticky", 32'(STATE), 32'd7);
    check("err_no_req", 32'(IMEM_REQ), 32'd0);

    // Reset mid-MEM abandons the access; a late READY is ignored
    do_reset();
    start_run();
    IMEM_READY = 1;
    @(negedge CLK);
    IMEM_READY = 0;
    IS_LOAD = 1;
    @(negedge CLK);
    @(negedge CLK);
    check("mid_mem_state", 32'(STATE), 32'd4);
    check("mid_mem_req", 32'(DMEM_REQ), 32'd1);
    RST = 1;
    @(negedge CLK);
    RST = 0;
    clear_class();
    check("rst_mem_req", 32'(DMEM_REQ), 32'd0);
    check("rst_mem_state", 32'(STATE), 32'd0);
    DMEM_READY = 1;
    @(negedge CLK);
    @(negedge CLK);
    DMEM_READY = 0;
    check("late_ready_state", 32'(STATE), 32'd0);
    check("late_ready_pc", PC, 32'h0);
    check("late_ready_retired", RETIRED, 32'd0);
    check("late_ready_reg_we", 32'(REG_WE), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
